// File: rtl/calc_sequencer.sv
// ----------------------------------------------------------------------------
// calc_sequencer
//
// Runs one operand set through an external combinational calculator. On an
// accepted start it latches op_a/op_b/op_mask, then walks the set bits of the
// mask in ascending order. For each opcode it drives calc_a/calc_b/calc_oper
// and waits SETTLE_CYCLES+1 edges for the calculator to settle. It then
// captures calc_out and presents it on a valid/ready result port. A one-cycle
// done pulse closes the run.
//
// Parameters
//   SETTLE_CYCLES  settle wait per opcode, legal range 1..15 (default 2)
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   start, op_a, op_b, op_mask  run request and its operands (sampled in IDLE)
//   calc_a, calc_b, calc_oper   registered drive to the calculator
//   calc_out                    calculator result
//   res_valid, res_ready        result handshake
//   res_oper, res_data          opcode and captured result
//   busy, done                  not-IDLE flag, end-of-run pulse
//
// Optional build macro CALC_SEQ_CHECK_EN adds res_err / err_count. Each
// captured result is compared against a built-in golden model of the
// calculator.
// ----------------------------------------------------------------------------
module calc_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] op_a,
    input  logic [3:0] op_b,
    input  logic [7:0] op_mask,
    output logic [3:0] calc_a,
    output logic [3:0] calc_b,
    output logic [2:0] calc_oper,
    input  logic [7:0] calc_out,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [2:0] res_oper,
    output logic [7:0] res_data,
    output logic       busy,
    output logic       done
`ifdef CALC_SEQ_CHECK_EN
    ,
    output logic       res_err,
    output logic [3:0] err_count
`endif
);

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    state_t     state;
    logic [7:0] mask_q;
    logic [3:0] settle_cnt;

    // first_*: lowest set bit of the incoming mask (used when starting).
    // next_*:  lowest latched mask bit strictly above the current opcode.
    logic [2:0] first_idx;
    logic       first_hit;
    logic [2:0] next_idx;
    logic       next_hit;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise paths that skip an assignment infer a latch.
        first_idx = '0;
        first_hit = 1'b0;
        next_idx  = '0;
        next_hit  = 1'b0;
        // Scan downwards so the lowest matching bit is the one left standing.
        for (int i = 7; i >= 0; i--) begin
            if (op_mask[i]) begin
                first_idx = 3'(i);
                first_hit = 1'b1;
            end
            if (mask_q[i] && (i > int'(calc_oper))) begin
                next_idx = 3'(i);
                next_hit = 1'b1;
            end
        end
    end

`ifdef CALC_SEQ_CHECK_EN
    logic [7:0] golden;

    always_comb begin
        golden = '0;
        unique case (calc_oper)
            3'd0: golden = {4'b0, calc_a} + {4'b0, calc_b};
            3'd1: golden = {4'b0, calc_a} - {4'b0, calc_b};
            3'd2: golden = {4'b0, calc_a} * {4'b0, calc_b};
            3'd3: golden = (calc_b == 4'd0) ? 8'hFF : {4'b0, calc_a / calc_b};
            3'd4: golden = {4'b0, calc_a & calc_b};
            3'd5: golden = {4'b0, calc_a | calc_b};
            3'd6: golden = {4'b0, calc_a ^ calc_b};
            3'd7: golden = {4'b0, ~calc_a};
        endcase
    end
`endif

    // NOTE: clocked state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            mask_q     <= '0;
            settle_cnt <= '0;
            calc_a     <= '0;
            calc_b     <= '0;
            calc_oper  <= '0;
            res_valid  <= 1'b0;
            res_oper   <= '0;
            res_data   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef CALC_SEQ_CHECK_EN
            res_err    <= 1'b0;
            err_count  <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        mask_q <= op_mask;
                        busy   <= 1'b1;
                        if (first_hit) begin
                            calc_a     <= op_a;
                            calc_b     <= op_b;
                            calc_oper  <= first_idx;
                            settle_cnt <= SETTLE_INIT;
                            state      <= S_WAIT;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end

                // Capture happens on the edge after the counter reads zero,
                // giving SETTLE_CYCLES+1 edges from load to res_valid.
                S_WAIT: begin
                    if (settle_cnt == 4'd0) begin
                        res_data  <= calc_out;
                        res_oper  <= calc_oper;
                        res_valid <= 1'b1;
`ifdef CALC_SEQ_CHECK_EN
                        res_err   <= (calc_out != golden);
`endif
                        state     <= S_EMIT;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end

                S_EMIT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
`ifdef CALC_SEQ_CHECK_EN
                        if (res_err && (err_count != 4'hF))
                            err_count <= err_count + 4'd1;
`endif
                        if (next_hit) begin
                            calc_oper  <= next_idx;
                            settle_cnt <= SETTLE_INIT;
                            state      <= S_WAIT;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_calc_sequencer
//
// Drives calc_sequencer against an ideal calculator model. The calculator
// can be made to return 8'h00 for opcode 2. Each run's expected opcode
// order, results, latency and handshake timing are derived from the operand
// set alone. Runs cover directed cases and randomized operand sets.
// ----------------------------------------------------------------------------
module tb_calc_sequencer;

    localparam int SETTLE = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [7:0] op_mask;
    logic [3:0] calc_a;
    logic [3:0] calc_b;
    logic [2:0] calc_oper;
    logic [7:0] calc_out;
    logic       res_valid;
    logic       res_ready;
    logic [2:0] res_oper;
    logic [7:0] res_data;
    logic       busy;
    logic       done;
`ifdef CALC_SEQ_CHECK_EN
    logic       res_err;
    logic [3:0] err_count;
`endif

    int vectors     = 0;
    int miscompares = 0;
    bit corrupt     = 1'b0;
    int exp_err_count = 0;

    logic [7:0] seen_data[$];
    int         seen_oper[$];

    calc_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_mask   (op_mask),
        .calc_a    (calc_a),
        .calc_b    (calc_b),
        .calc_oper (calc_oper),
        .calc_out  (calc_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_oper  (res_oper),
        .res_data  (res_data),
        .busy      (busy),
        .done      (done)
`ifdef CALC_SEQ_CHECK_EN
        ,
        .res_err   (res_err),
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    // Arithmetic meaning of each opcode, written with plain integers.
    function automatic logic [7:0] ref_result(input logic [3:0] a, input logic [3:0] b,
                                              input int op);
        logic [3:0] na;
        na = ~a;
        case (op)
            0:       return 8'(int'(a) + int'(b));
            1:       return 8'(int'(a) - int'(b));
            2:       return 8'(int'(a) * int'(b));
            3:       return (b == 4'd0) ? 8'hFF : 8'(int'(a) / int'(b));
            4:       return 8'(a & b);
            5:       return 8'(a | b);
            6:       return 8'(a ^ b);
            default: return {4'b0, na};
        endcase
    endfunction

    always_comb begin
        calc_out = (corrupt && calc_oper == 3'd2) ? 8'h00
                 : ref_result(calc_a, calc_b, int'(calc_oper));
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_calc_a"},    calc_a,    0);
        check({tag, "_calc_b"},    calc_b,    0);
        check({tag, "_calc_oper"}, calc_oper, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_oper"},  res_oper,  0);
        check({tag, "_res_data"},  res_data,  0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
`ifdef CALC_SEQ_CHECK_EN
        check({tag, "_res_err"},   res_err,   0);
        check({tag, "_err_count"}, err_count, 0);
`endif
    endtask

    // One run. stall: cycles res_ready is held low at the first result.
    // poke: pulse start with a=1 during the first wait. rst_at: opcode
    // index during whose wait reset is asserted (-1 = never).
    task automatic run(input logic [3:0] a, input logic [3:0] b, input logic [7:0] mask,
                       input int stall, input bit poke, input int rst_at);
        int         ops[$];
        int         cyc;
        logic [7:0] exp_data;
        bit         exp_err;
        for (int i = 0; i < 8; i++)
            if (mask[i]) ops.push_back(i);
        seen_data.delete();
        seen_oper.delete();
        res_ready = 1'b1;
        start     = 1'b1;
        op_a      = a;
        op_b      = b;
        op_mask   = mask;
        tick();
        start   = 1'b0;
        op_a    = 4'($urandom);
        op_b    = 4'($urandom);
        op_mask = 8'($urandom);
        if (ops.size() == 0) begin
            check("empty_done",  done,      1);
            check("empty_valid", res_valid, 0);
            check("empty_busy",  busy,      1);
        end
        foreach (ops[k]) begin
            cyc = 0;
            while (res_valid !== 1'b1 && cyc < 40) begin
                if (k == 0 && poke && cyc == 1) begin
                    start   = 1'b1;
                    op_a    = 4'd1;
                    op_mask = 8'hFF;
                end
                if (k == rst_at && cyc == 1) begin
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    exp_err_count = 0;
                    check_reset("midrun_reset");
                    repeat (SETTLE + 4) begin
                        tick();
                        check("no_done_after_reset",  done,      0);
                        check("idle_after_reset",     busy,      0);
                        check("no_valid_after_reset", res_valid, 0);
                    end
                    return;
                end
                tick();
                start = 1'b0;
                cyc++;
                check("calc_a_hold", calc_a, a);
                check("calc_b_hold", calc_b, b);
                check("run_busy",    busy,   1);
                check("run_done_low", done,  0);
            end
            check("latency", cyc, SETTLE + 1);
            exp_data = (corrupt && ops[k] == 2) ? 8'h00 : ref_result(a, b, ops[k]);
            exp_err  = (exp_data != ref_result(a, b, ops[k]));
            seen_data.push_back(res_data);
            seen_oper.push_back(int'(res_oper));
            check("res_valid", res_valid, 1);
            check("res_oper",  res_oper,  ops[k]);
            check("res_data",  res_data,  exp_data);
            check("calc_oper", calc_oper, ops[k]);
`ifdef CALC_SEQ_CHECK_EN
            check("res_err", res_err, exp_err);
`endif
            if (k == 0 && stall > 0) begin
                res_ready = 1'b0;
                repeat (stall) begin
                    tick();
                    check("stall_valid", res_valid, 1);
                    check("stall_data",  res_data,  exp_data);
                    check("stall_oper",  res_oper,  ops[k]);
                end
                res_ready = 1'b1;
            end
            tick();
            if (exp_err && exp_err_count < 15) exp_err_count++;
            check("valid_drop", res_valid, 0);
`ifdef CALC_SEQ_CHECK_EN
            check("err_count", err_count, exp_err_count);
`endif
            if (k == ops.size() - 1) check("done_pulse",  done, 1);
            else                     check("done_midrun", done, 0);
        end
        // A start presented in the DONE cycle must not launch a run.
        start   = 1'b1;
        op_a    = 4'($urandom);
        op_mask = 8'hFF;
        tick();
        start = 1'b0;
        check("done_one_cycle",  done, 0);
        check("idle_after_done", busy, 0);
        tick();
        check("done_start_ignored", busy, 0);
    endtask

    initial begin
        logic [7:0] ff_tab [8];
        ff_tab = '{8'h0C, 8'h06, 8'h1B, 8'h03, 8'h01, 8'h0B, 8'h0A, 8'h06};

        rst       = 1'b1;
        start     = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_mask   = '0;
        res_ready = 1'b0;
        tick();
        tick();
        check_reset("reset_state");
        rst = 1'b0;
        tick();

        // Full mask, a=9 b=3: fixed result table.
        run(4'd9, 4'd3, 8'hFF, 0, 1'b0, -1);
        check("ff_count", seen_data.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check("ff_table_data", seen_data[i], ff_tab[i]);
            check("ff_table_oper", seen_oper[i], i);
        end

        // Empty mask.
        run(4'd5, 4'd7, 8'h00, 0, 1'b0, -1);

        // Sparse mask with consumer back-pressure.
        run(4'd9, 4'd3, 8'h24, 5, 1'b0, -1);
        check("sparse_count", seen_oper.size(), 2);

        // Start while busy is ignored.
        run(4'd9, 4'd3, 8'hFF, 0, 1'b1, -1);

        // Reset during the third opcode's wait, then a normal run.
        run(4'd9, 4'd3, 8'hFF, 0, 1'b0, 2);
        run(4'd9, 4'd3, 8'hFF, 0, 1'b0, -1);

        // Randomized operand sets.
        for (int n = 0; n < 40; n++)
            run(4'($urandom), 4'($urandom), 8'($urandom),
                int'($urandom_range(0, 3)), 1'b0, -1);

`ifdef CALC_SEQ_CHECK_EN
        corrupt = 1'b1;
        run(4'd9, 4'd3, 8'hFF, 0, 1'b0, -1);
        check("err_count_at_done", err_count, 1);
        for (int n = 0; n < 16; n++)
            run(4'd9, 4'd3, 8'h04, 0, 1'b0, -1);
        check("err_count_saturated", err_count, 15);
        corrupt = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_err_count = 0;
        check_reset("final_reset");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
